// File: rtl/if_stage_prefetch.sv
// if_stage_prefetch: instruction fetch stage with loadable memory, PC and prefetch FIFO to decode.
module if_stage_prefetch #(
  parameter int          DATA_W     = 32,
  parameter int          IMEM_DEPTH = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]             load_data,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_instr,
  output logic [31:0]                   out_pc,
  output logic [31:0]                   fetch_pc,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [31:0]                   retired_cnt
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [IMEM_DEPTH];
  logic [DATA_W-1:0] instr_q [FIFO_DEPTH];
  logic [31:0] pcb_q [FIFO_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, ret_q, ret_d;
  logic push, pop, full;
  assign full = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign out_valid = cnt_q != '0;
  assign pop = out_valid && out_ready;
  assign push = fetch_en && !load_en && !redirect_valid && (!full || pop);
  assign out_instr = out_valid ? instr_q[rd_q] : '0;
  assign out_pc = out_valid ? pcb_q[rd_q] : '0;
  assign fetch_pc = pc_q;
  assign fifo_count = cnt_q;
  assign retired_cnt = ret_q;
  always_comb begin
    pc_d = redirect_valid ? (redirect_pc & ~32'h3) : push ? pc_q + 32'd4 : pc_q;
    rd_d = redirect_valid ? '0 : rd_q + PW'(pop);
    wr_d = redirect_valid ? '0 : wr_q + PW'(push);
    cnt_d = redirect_valid ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ret_d = ret_q + 32'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      ret_q <= '0;
    end else begin
      pc_q <= pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
      ret_q <= ret_d;
    end
  end
  // Storage needs no reset: entries are only visible while counted in cnt_q.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_q[wr_q] <= mem[pc_q[IW+1:2]];
      pcb_q[wr_q] <= pc_q;
    end
    if (!reset && load_en) mem[load_addr] <= load_data;
  end
endmodule

// File: tb/tb_if_stage_prefetch.sv
// tb_if_stage_prefetch: scoreboard bench for the fetch stage against a cycle model.
module tb_if_stage_prefetch;
  logic clk, reset, load_en, fetch_en, redirect_valid, out_ready, out_valid;
  logic [3:0] load_addr;
  logic [31:0] load_data, redirect_pc, out_instr, out_pc, fetch_pc, retired_cnt;
  logic [2:0] fifo_count;
  int checks = 0, failures = 0;
  logic [31:0] mmem [16];
  logic [31:0] mpc, mret, hold_pc;
  logic [63:0] mq [$];
  bit seen;
  logic [31:0] prog [7] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'h214A0002,
                            32'hAC0A0004, 32'h8C0B0004, 32'h116BFFFC};

  if_stage_prefetch dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fetch_pc(fetch_pc), .fifo_count(fifo_count), .retired_cnt(retired_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    bit pop, push;
    logic [63:0] ent;
    chk("valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count", 64'(fifo_count), 64'(mq.size()));
    chk("fetch_pc", 64'(fetch_pc), 64'(mpc));
    chk("retired", 64'(retired_cnt), 64'(mret));
    if (mq.size() != 0) begin
      chk("out_pc", 64'(out_pc), 64'(mq[0][63:32]));
      chk("out_instr", 64'(out_instr), 64'(mq[0][31:0]));
    end else begin
      chk("out_pc_empty", 64'(out_pc), 64'd0);
      chk("out_instr_empty", 64'(out_instr), 64'd0);
    end
    pop = mq.size() != 0 && out_ready;
    push = fetch_en && !load_en && !redirect_valid && (mq.size() < 4 || pop);
    ent = {mpc, mmem[mpc[5:2]]};
    @(posedge clk);
    if (reset) begin
      mq.delete();
      mpc = 32'h0;
      mret = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        mret++;
      end
      if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
        mq.push_back(ent);
        mpc += 4;
      end
      if (load_en) mmem[load_addr] = load_data;
    end
    @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1;
    redirect_pc = t;
    cyc();
    redirect_valid = 0;
  endtask

  initial begin
    reset = 1; load_en = 0; load_addr = 0; load_data = 0; fetch_en = 0;
    redirect_valid = 0; redirect_pc = 0; out_ready = 0;
    mpc = 0; mret = 0;
    for (int i = 0; i < 16; i++) mmem[i] = 0;
    @(negedge clk);
    cyc();
    cyc();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      load_en = 1;
      load_addr = 4'(i);
      load_data = i < 7 ? prog[i] : 32'h1000_0000 + i;
      cyc();
    end
    load_en = 0;
    fetch_en = 1; out_ready = 1;
    repeat (7) cyc();
    fetch_en = 0;
    cyc();
    chk("ret7", 64'(retired_cnt), 64'd7);
    redir(32'h0);
    fetch_en = 1; out_ready = 0;
    repeat (6) cyc();
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_pc", 64'(fetch_pc), 64'h10);
    out_ready = 1;
    repeat (4) cyc();
    chk("steady_count", 64'(fifo_count), 64'd4);
    fetch_en = 0;
    cyc();
    chk("three", 64'(fifo_count), 64'd3);
    fetch_en = 1;
    redir(32'h7);
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_pc", 64'(fetch_pc), 64'h4);
    cyc();
    chk("redir_head_pc", 64'(out_pc), 64'h4);
    chk("redir_head_instr", 64'(out_instr), 64'h20090003);
    redir(32'h38);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && out_pc == 32'h40) begin
        seen = 1;
        chk("wrap_instr", 64'(out_instr), 64'h20080005);
      end
      cyc();
    end
    chk("wrap_seen", 64'(seen), 64'd1);
    hold_pc = fetch_pc;
    load_en = 1; load_addr = 2; load_data = 32'hDEADBEEF;
    cyc();
    load_en = 0;
    chk("load_hold", 64'(fetch_pc), 64'(hold_pc));
    redir(32'h8);
    cyc();
    chk("load_word", 64'(out_instr), 64'hDEADBEEF);
    reset = 1;
    cyc();
    reset = 0;
    repeat (6) cyc();
    out_ready = 0;
    cyc();
    chk("pre_rst_count", 64'(fifo_count), 64'd2);
    chk("pre_rst_ret", 64'(retired_cnt), 64'd5);
    reset = 1;
    cyc();
    reset = 0; fetch_en = 0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ret", 64'(retired_cnt), 64'd0);
    fetch_en = 1; out_ready = 1;
    cyc();
    chk("rst_mem0", 64'(out_instr), 64'h20080005);
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
- Parametrised instruction-fetch stage for the pipelined processor.
- Replaces the fixed 16-word instruction array, which is currently loaded by hierarchical writes, with a proper load port.
- Contains a program counter, a prefetch FIFO and a valid/ready handshake to decode.
- Accepts branch/jump redirects from later stages; a redirect flushes all prefetched words.

Parameters:
- DATA_W, 32: instruction width.
- IMEM_DEPTH, 16: instruction memory words. Must be a power of 2, at least 2.
- FIFO_DEPTH, 4: prefetch buffer entries. Must be a power of 2, at least 2.
- RESET_PC, 32'h0000_0000: byte address fetched first after reset.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Synchronous, active-high reset.
- load_en  in  1  Write one word into instruction memory this cycle.
- load_addr  in  $clog2(IMEM_DEPTH)  Word index for the write.
- load_data  in  DATA_W  Word to write.
- fetch_en  in  1  Enables fetching. When low, the PC holds and nothing is pushed.
- redirect_valid  in  1  Branch/jump taken; load a new PC.
- redirect_pc  in  32  Byte target. Bits [1:0] are forced to 0.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  Decode accepts the head.
- out_instr  out  DATA_W  Head instruction word.
- out_pc  out  32  Byte PC of the head instruction.
- fetch_pc  out  32  Current fetch PC.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  Current FIFO occupancy.
- retired_cnt  out  32  Count of accepted handshakes. Wraps at 2^32.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC; FIFO empty; out_valid = 0; fifo_count = 0; retired_cnt = 0.
  - out_instr and out_pc read 0 while the FIFO is empty.
  - Instruction memory contents are NOT cleared by reset.
- Memory read:
  - Asynchronous. Word index = fetch_pc[$clog2(IMEM_DEPTH)+1:2]; upper PC bits are ignored, so the index wraps modulo IMEM_DEPTH.
- Write:
  - Memory updates at the clock edge when load_en = 1.
- Push condition:
  - push = fetch_en && !load_en && !redirect_valid && (!full || pop).
  - On push: FIFO takes {fetch_pc, mem[index]} and fetch_pc <= fetch_pc + 4, wrapping at 2^32.
- Pop condition:
  - pop = out_valid && out_ready. Each pop increments retired_cnt.
- Full FIFO: push is allowed in the same cycle as a pop, so occupancy stays FIFO_DEPTH.
- Empty FIFO: out_valid = 0 and pop is impossible. A word pushed this cycle appears at the head next cycle, so fetch-to-decode latency is 1 cycle.
- Redirect (highest priority):
  - If a pop coincides with the redirect, that transfer completes and retired_cnt increments.
  - The FIFO is then cleared (fifo_count <= 0), fetch_pc <= {redirect_pc[31:2], 2'b00}, and there is no push.
  - out_valid = 0 the next cycle. The first target word is visible 2 cycles after redirect_valid is sampled.
- load_en with redirect: both take effect. The memory write and the redirect are independent.
- load_en while fetching: fetch stalls for that cycle, meaning no push and the PC holds. A word written at index k is returned by the first fetch of k in any later cycle.
- reset mid-operation: returns all state above to reset values next edge, discarding in-flight FIFO entries. Memory keeps its contents. Reset overrides redirect and load.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count must never exceed FIFO_DEPTH or underflow.

Test Plan:
- Load mem[0..6] = 20080005, 20090003, 01095020, 214A0002, AC0A0004, 8C0B0004, 116BFFFC. Release reset with fetch_en=1 and out_ready=1.
  - -> out_pc 0,4,…,0x18 on consecutive cycles starting 1 cycle after reset; out_instr matches; retired_cnt = 7 after the 7th accept.
- Hold out_ready=0 with fetch_en=1.
  - -> fifo_count reaches FIFO_DEPTH (4) and fetch_pc stops at 0x10.
  - Raise out_ready: one pop and one push per cycle, count stays 4, order is preserved.
- Assert redirect_valid with redirect_pc=0x0000_0007 while 3 entries are buffered and out_ready=1.
  - -> that cycle's head is accepted, FIFO is cleared, fetch_pc = 0x4, out_valid low for 1 cycle, then out_pc = 0x4 with 20090003.
- Run fetch to PC 0x3C, then 0x40.
  - -> the word at 0x40 equals mem[0] (wrap at IMEM_DEPTH=16).
- Pulse load_en (addr 2, data DEADBEEF) during active fetch.
  - -> no push that cycle, PC holds.
  - Redirect to 0x8 -> out_instr = DEADBEEF.
- Assert reset with 2 entries buffered and retired_cnt=5.
  - -> next cycle out_valid=0, fifo_count=0, retired_cnt=0, fetch_pc=RESET_PC; memory unchanged (first word re-fetched = mem[0]).
